// File: rtl/spectrum_packet_checker_pkg.sv
// -----------------------------------------------------------------------------
// spectrum_packet_checker_pkg
// Shared definitions for the spectrum packet checker:
//   - framing word constants (identical to the acquisition stage's encoder)
//   - parser state encoding (also exported on state_dbg)
//   - error flag bit positions
//   - saturating counter helper
// -----------------------------------------------------------------------------
package spectrum_packet_checker_pkg;

   localparam int DATA_W = 32;

   // Framing words emitted by the sensor acquisition stage
   localparam logic [DATA_W-1:0] HEADER_WORD = 32'hAAAAAAAA;
   localparam logic [DATA_W-1:0] FOOTER_WORD = 32'h55555555;
   localparam logic [DATA_W-1:0] TLAST_WORD  = 32'hBBBBBBBB;

   // Payload lengths for the two acquisition modes
   localparam int PROC_LEN = 3;
   localparam int RAW_LEN  = 512;

   // Parser states; the numeric values are visible to software via state_dbg
   typedef enum logic [2:0] {
      ST_HUNT       = 3'd0,
      ST_TSTAMP     = 3'd1,
      ST_PAYLOAD    = 3'd2,
      ST_FOOTER_CHK = 3'd3,
      ST_POST       = 3'd4
   } parser_state_t;

   // Bit positions inside err_flags
   localparam int ERR_SYNC   = 0;
   localparam int ERR_FOOTER = 1;
   localparam int ERR_TLAST  = 2;
   localparam int ERR_TS     = 3;
   localparam int ERR_W      = 4;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/spectrum_packet_checker_axis_skid_buffer.sv
// -----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry registered AXI-Stream slice. Both s_ready and all m_* outputs come
// straight from flops, so neither direction has a combinational path through
// this block. One entry is the output register, the other catches the word
// that arrives in the cycle the downstream stalls.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_data/s_last      upstream payload
//   s_valid/s_ready    upstream handshake (s_ready = skid entry empty)
//   m_data/m_last      downstream payload, held stable while stalled
//   m_valid/m_ready    downstream handshake
// -----------------------------------------------------------------------------
module axis_skid_buffer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready
);

   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic              skid_last;
   logic              ready_r;
   logic              in_xfer;
   logic              out_free;

   always_comb begin
      in_xfer  = s_valid && ready_r;
      // Output register can take a new word if it is empty or being drained
      out_free = !out_valid || m_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
         ready_r    <= 1'b0;
      end else if (out_free) begin
         // The skid entry is older than anything on the input, so it goes first.
         // in_xfer cannot be set together with skid_valid because ready_r is low.
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            out_last   <= skid_last;
            skid_valid <= 1'b0;
         end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= s_data;
            out_last  <= s_last;
         end else begin
            out_valid <= 1'b0;
         end
         ready_r <= 1'b1;
      end else if (in_xfer) begin
         // Output stalled: park the word and stop accepting
         skid_valid <= 1'b1;
         skid_data  <= s_data;
         skid_last  <= s_last;
         ready_r    <= 1'b0;
      end
   end

   assign s_ready = ready_r;
   assign m_valid = out_valid;
   assign m_data  = out_data;
   assign m_last  = out_last;

endmodule

// File: rtl/spectrum_packet_checker.sv
// -----------------------------------------------------------------------------
// spectrum_packet_checker
// Sits between the sensor acquisition stream and the DMA. Every word passes
// unchanged through a registered skid slice; in parallel the accepted upstream
// words are parsed (header, timestamp, payload, footer, optional TLAST word)
// and framing statistics are kept for the PS.
//
// Ports:
//   master_clock, resetn    clock, asynchronous active-low reset
//   raw_mode                payload mode, latched when a header is accepted
//   clear_stats             one-cycle pulse zeroing counters, flags, timestamps
//   s_tdata/s_tvalid/s_tlast/s_tready   upstream AXI-Stream slave
//   m_tdata/m_tvalid/m_tlast/m_tready   downstream AXI-Stream master
//   last_timestamp          timestamp of the latest good packet
//   timestamp_delta         difference to the previous good timestamp (mod 2^32)
//   packet_count            good packets, wrapping
//   frame_count             accepted TLAST words, wrapping
//   err_count               framing error events, saturating
//   err_flags               sticky {ts, tlast, footer, sync}
//   state_dbg               parser state
// -----------------------------------------------------------------------------
module spectrum_packet_checker
   import spectrum_packet_checker_pkg::*;
#(
   parameter logic [31:0] HEADER_VALUE = HEADER_WORD,
   parameter logic [31:0] FOOTER_VALUE = FOOTER_WORD,
   parameter logic [31:0] TLAST_VALUE  = TLAST_WORD,
   parameter int          PROC_WORDS   = PROC_LEN,
   parameter int          RAW_WORDS    = RAW_LEN
) (
   input  logic        master_clock,
   input  logic        resetn,
   input  logic        raw_mode,
   input  logic        clear_stats,
   input  logic [31:0] s_tdata,
   input  logic        s_tvalid,
   input  logic        s_tlast,
   output logic        s_tready,
   output logic [31:0] m_tdata,
   output logic        m_tvalid,
   output logic        m_tlast,
   input  logic        m_tready,
   output logic [31:0] last_timestamp,
   output logic [31:0] timestamp_delta,
   output logic [15:0] packet_count,
   output logic [15:0] frame_count,
   output logic [15:0] err_count,
   output logic [3:0]  err_flags,
   output logic [2:0]  state_dbg
);

   localparam int MAX_WORDS = (RAW_WORDS > PROC_WORDS) ? RAW_WORDS : PROC_WORDS;
   localparam int CNT_W     = $clog2(MAX_WORDS + 1);

   parser_state_t      state;
   parser_state_t      next_state;
   logic               xfer;
   logic               mode_raw;
   logic [CNT_W-1:0]   pay_cnt;
   logic [CNT_W-1:0]   pay_cnt_inc;
   logic [CNT_W-1:0]   pay_len;
   logic [31:0]        pending_ts;
   logic               sync_reported;
   logic               have_ts;

   logic               is_header;
   logic               is_footer;
   logic               is_tlast_word;
   logic               tlast_ok;
   logic               tlast_abort;

   logic [ERR_W-1:0]   err_vec;
   logic               good_pkt;
   logic               frame_evt;
   logic               header_acc;
   logic               ts_capture;

   // --------------------------------------------------------------------------
   // Datapath: registered pass-through
   // --------------------------------------------------------------------------
   axis_skid_buffer #(
      .DATA_W (32)
   ) u_skid (
      .clk     (master_clock),
      .rst_n   (resetn),
      .s_data  (s_tdata),
      .s_last  (s_tlast),
      .s_valid (s_tvalid),
      .s_ready (s_tready),
      .m_data  (m_tdata),
      .m_last  (m_tlast),
      .m_valid (m_tvalid),
      .m_ready (m_tready)
   );

   // --------------------------------------------------------------------------
   // Word classification
   // --------------------------------------------------------------------------
   always_comb begin
      xfer          = s_tvalid && s_tready;
      is_header     = (s_tdata == HEADER_VALUE);
      is_footer     = (s_tdata == FOOTER_VALUE);
      is_tlast_word = (s_tdata == TLAST_VALUE);
      // The only place tlast is legal is on the TLAST word right after a footer
      tlast_ok      = (state == ST_POST) && is_tlast_word && s_tlast;
      tlast_abort   = s_tlast && !tlast_ok;
      pay_len       = mode_raw ? CNT_W'(RAW_WORDS) : CNT_W'(PROC_WORDS);
      pay_cnt_inc   = pay_cnt + CNT_W'(1);
   end

   // --------------------------------------------------------------------------
   // Parser FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge master_clock or negedge resetn) begin
      if (!resetn) begin
         state <= ST_HUNT;
      end else begin
         state <= next_state;
      end
   end

   // --------------------------------------------------------------------------
   // Parser FSM: next state
   // --------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      if (xfer) begin
         if (tlast_abort) begin
            next_state = ST_HUNT;
         end else begin
            unique case (state)
               ST_HUNT:       if (is_header) next_state = ST_TSTAMP;
               ST_TSTAMP:     next_state = ST_PAYLOAD;
               ST_PAYLOAD:    if (pay_cnt_inc == pay_len) next_state = ST_FOOTER_CHK;
               ST_FOOTER_CHK: next_state = is_footer ? ST_POST : ST_HUNT;
               ST_POST:       next_state = is_header ? ST_TSTAMP : ST_HUNT;
               default:       next_state = ST_HUNT;
            endcase
         end
      end
   end

   // --------------------------------------------------------------------------
   // Parser FSM: per-word events
   // A word carrying an unexpected tlast aborts the packet, so a footer
   // with tlast set is not counted as a good packet.
   // --------------------------------------------------------------------------
   always_comb begin
      err_vec    = '0;
      good_pkt   = 1'b0;
      frame_evt  = 1'b0;
      header_acc = 1'b0;
      ts_capture = 1'b0;
      if (xfer) begin
         err_vec[ERR_TLAST] = tlast_abort;
         unique case (state)
            ST_HUNT: begin
               if (!is_header) begin
                  // One sync error per hunt episode, not one per junk word
                  err_vec[ERR_SYNC] = !sync_reported;
               end else begin
                  header_acc = !tlast_abort;
               end
            end
            ST_TSTAMP: begin
               ts_capture = !tlast_abort;
            end
            ST_FOOTER_CHK: begin
               if (!is_footer) begin
                  err_vec[ERR_FOOTER] = 1'b1;
               end else begin
                  good_pkt = !tlast_abort;
               end
            end
            ST_POST: begin
               if (is_header) begin
                  header_acc = !tlast_abort;
               end else if (tlast_ok) begin
                  frame_evt = 1'b1;
               end else begin
                  err_vec[ERR_SYNC] = 1'b1;
                  if (is_tlast_word) err_vec[ERR_TLAST] = 1'b1;
               end
            end
            default: ;
         endcase
         // First good packet after reset/clear has nothing to compare against
         if (good_pkt && have_ts && (pending_ts == last_timestamp)) begin
            err_vec[ERR_TS] = 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Parser context: mode, payload count, pending timestamp, hunt episode
   // --------------------------------------------------------------------------
   always_ff @(posedge master_clock or negedge resetn) begin
      if (!resetn) begin
         mode_raw      <= 1'b0;
         pay_cnt       <= '0;
         pending_ts    <= '0;
         sync_reported <= 1'b0;
      end else if (xfer) begin
         if (header_acc) begin
            mode_raw      <= raw_mode;
            sync_reported <= 1'b0;
         end else if (err_vec[ERR_SYNC]) begin
            sync_reported <= 1'b1;
         end
         if (ts_capture) begin
            pending_ts <= s_tdata;
            pay_cnt    <= '0;
         end else if (state == ST_PAYLOAD) begin
            pay_cnt <= pay_cnt_inc;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Statistics; clear_stats overrides any event in the same cycle
   // --------------------------------------------------------------------------
   always_ff @(posedge master_clock or negedge resetn) begin
      if (!resetn) begin
         packet_count    <= '0;
         frame_count     <= '0;
         err_count       <= '0;
         err_flags       <= '0;
         last_timestamp  <= '0;
         timestamp_delta <= '0;
         have_ts         <= 1'b0;
      end else if (clear_stats) begin
         packet_count    <= '0;
         frame_count     <= '0;
         err_count       <= '0;
         err_flags       <= '0;
         last_timestamp  <= '0;
         timestamp_delta <= '0;
         have_ts         <= 1'b0;
      end else begin
         if (good_pkt) begin
            packet_count    <= packet_count + 16'd1;
            timestamp_delta <= pending_ts - last_timestamp;
            last_timestamp  <= pending_ts;
            have_ts         <= 1'b1;
         end
         if (frame_evt) begin
            frame_count <= frame_count + 16'd1;
         end
         if (|err_vec) begin
            err_count <= sat_inc16(err_count);
            err_flags <= err_flags | err_vec;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_spectrum_packet_checker.sv
module tb_spectrum_packet_checker;

   localparam logic [31:0] HDR = 32'hAAAAAAAA;
   localparam logic [31:0] FTR = 32'h55555555;
   localparam logic [31:0] TLW = 32'hBBBBBBBB;

   logic        master_clock = 1'b0;
   logic        resetn       = 1'b0;
   logic        raw_mode     = 1'b0;
   logic        clear_stats  = 1'b0;
   logic [31:0] s_tdata      = '0;
   logic        s_tvalid     = 1'b0;
   logic        s_tlast      = 1'b0;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready     = 1'b0;
   logic [31:0] last_timestamp;
   logic [31:0] timestamp_delta;
   logic [15:0] packet_count;
   logic [15:0] frame_count;
   logic [15:0] err_count;
   logic [3:0]  err_flags;
   logic [2:0]  state_dbg;

   spectrum_packet_checker dut (
      .master_clock    (master_clock),
      .resetn          (resetn),
      .raw_mode        (raw_mode),
      .clear_stats     (clear_stats),
      .s_tdata         (s_tdata),
      .s_tvalid        (s_tvalid),
      .s_tlast         (s_tlast),
      .s_tready        (s_tready),
      .m_tdata         (m_tdata),
      .m_tvalid        (m_tvalid),
      .m_tlast         (m_tlast),
      .m_tready        (m_tready),
      .last_timestamp  (last_timestamp),
      .timestamp_delta (timestamp_delta),
      .packet_count    (packet_count),
      .frame_count     (frame_count),
      .err_count       (err_count),
      .err_flags       (err_flags),
      .state_dbg       (state_dbg)
   );

   always #5 master_clock = ~master_clock;

   int n_tests = 0;
   int n_fail  = 0;
   int ready_pct = 100;
   int gap_pct   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit rbit();
      return bit'($urandom_range(0, 1));
   endfunction

   // ---------------- forwarding scoreboard ----------------
   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } beat_t;
   beat_t exp_q[$];

   always @(posedge master_clock) begin
      #1;
      m_tready = ($urandom_range(0, 99) < ready_pct);
   end

   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = '0;
   beat_t       mon_b;
   always @(negedge master_clock) begin
      if (!resetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", {31'd0, m_tvalid}, 32'd1);
            check("hold_data", m_tdata, prev_data);
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL fwd_extra: got %h expected no word", m_tdata);
            end else begin
               mon_b = exp_q.pop_front();
               check("fwd_data", m_tdata, mon_b.d);
               check("fwd_last", {31'd0, m_tlast}, {31'd0, mon_b.l});
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
      end
   end

   // ---------------- packet-level reference model ----------------
   logic [15:0] e_pkt, e_frm, e_err;
   logic [3:0]  e_flags;
   logic [31:0] e_last, e_delta;
   bit          e_have;

   function automatic void m_clear();
      e_pkt = 0; e_frm = 0; e_err = 0; e_flags = 0;
      e_last = 0; e_delta = 0; e_have = 0;
   endfunction

   function automatic void m_err(input logic [3:0] mask);
      e_flags = e_flags | mask;
      if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
   endfunction

   // ---------------- drivers ----------------
   task automatic send_word(input logic [31:0] d, input logic l, input logic mode, input logic clr = 1'b0);
      int waited = 0;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
         @(posedge master_clock); #1;
      end
      s_tdata = d; s_tlast = l; raw_mode = mode; clear_stats = clr; s_tvalid = 1'b1;
      @(negedge master_clock);
      while (!s_tready && waited < 200) begin
         waited++;
         @(negedge master_clock);
      end
      if (!s_tready) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: got s_tready=0 expected 1 within 200 cycles");
      end else begin
         exp_q.push_back({d, l});
      end
      @(posedge master_clock); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0; clear_stats = 1'b0;
   endtask

   task automatic pkt(input bit mode, input logic [31:0] ts, input bit bad_footer);
      int n = mode ? 512 : 3;
      send_word(HDR, 1'b0, mode);
      send_word(ts, 1'b0, rbit());
      for (int i = 0; i < n; i++) send_word($urandom, 1'b0, rbit());
      if (bad_footer) begin
         send_word($urandom & 32'h0FFFFFFF, 1'b0, rbit());
         m_err(4'b0010);
      end else begin
         send_word(FTR, 1'b0, rbit());
         if (e_have && ts == e_last) m_err(4'b1000);
         e_delta = ts - e_last;
         e_last  = ts;
         e_have  = 1;
         e_pkt   = e_pkt + 16'd1;
      end
   endtask

   task automatic frame_end();
      send_word(TLW, 1'b1, rbit());
      e_frm = e_frm + 16'd1;
   endtask

   task automatic junk(input int n);
      for (int i = 0; i < n; i++) send_word($urandom & 32'h0FFFFFFF, 1'b0, rbit());
      m_err(4'b0001);
   endtask

   task automatic check_stats(input string tag);
      check({tag, ".pkt"},   {16'd0, packet_count}, {16'd0, e_pkt});
      check({tag, ".frm"},   {16'd0, frame_count},  {16'd0, e_frm});
      check({tag, ".errc"},  {16'd0, err_count},    {16'd0, e_err});
      check({tag, ".flags"}, {28'd0, err_flags},    {28'd0, e_flags});
      check({tag, ".last"},  last_timestamp,        e_last);
      check({tag, ".delta"}, timestamp_delta,       e_delta);
   endtask

   task automatic do_clear(input string tag);
      clear_stats = 1'b1;
      @(posedge master_clock); #1;
      clear_stats = 1'b0;
      m_clear();
      check_stats(tag);
   endtask

   task automatic drain();
      int t = 0;
      ready_pct = 100;
      while (exp_q.size() != 0 && t < 2000) begin
         @(posedge master_clock); #1;
         t++;
      end
      check("drain_empty", exp_q.size(), 32'd0);
      repeat (2) @(posedge master_clock);
      #1;
   endtask

   // ---------------- directed word table ----------------
   typedef struct {
      logic [31:0] d;
      logic        l;
      logic [2:0]  st;
      logic [3:0]  fl;
      logic [15:0] ec;
      logic [15:0] pk;
      logic [15:0] fr;
   } vec_t;
   vec_t tbl[32];

   function automatic vec_t mkv(input logic [31:0] d, input logic l, input logic [2:0] st,
                                input logic [3:0] fl, input logic [15:0] ec,
                                input logic [15:0] pk, input logic [15:0] fr);
      vec_t v;
      v.d = d; v.l = l; v.st = st; v.fl = fl; v.ec = ec; v.pk = pk; v.fr = fr;
      return v;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // junk, processed packet, frame end
      tbl[0]  = mkv(32'h00000000, 0, 0, 4'h1, 1, 0, 0);
      tbl[1]  = mkv(32'h00000001, 0, 0, 4'h1, 1, 0, 0);
      tbl[2]  = mkv(HDR,          0, 1, 4'h1, 1, 0, 0);
      tbl[3]  = mkv(32'h00000100, 0, 2, 4'h1, 1, 0, 0);
      tbl[4]  = mkv(32'h11111111, 0, 2, 4'h1, 1, 0, 0);
      tbl[5]  = mkv(32'h22222222, 0, 2, 4'h1, 1, 0, 0);
      tbl[6]  = mkv(32'h33333333, 0, 3, 4'h1, 1, 0, 0);
      tbl[7]  = mkv(FTR,          0, 4, 4'h1, 1, 1, 0);
      tbl[8]  = mkv(TLW,          1, 0, 4'h1, 1, 1, 1);
      // framing words inside payload are ignored; bad footer
      tbl[9]  = mkv(HDR,          0, 1, 4'h1, 1, 1, 1);
      tbl[10] = mkv(32'h00000180, 0, 2, 4'h1, 1, 1, 1);
      tbl[11] = mkv(HDR,          0, 2, 4'h1, 1, 1, 1);
      tbl[12] = mkv(FTR,          0, 2, 4'h1, 1, 1, 1);
      tbl[13] = mkv(TLW,          0, 3, 4'h1, 1, 1, 1);
      tbl[14] = mkv(32'h12345678, 0, 0, 4'h3, 2, 1, 1);
      // header carrying tlast
      tbl[15] = mkv(HDR,          1, 0, 4'h7, 3, 1, 1);
      tbl[16] = mkv(HDR,          0, 1, 4'h7, 3, 1, 1);
      tbl[17] = mkv(32'h00000200, 0, 2, 4'h7, 3, 1, 1);
      tbl[18] = mkv(32'h44444444, 0, 2, 4'h7, 3, 1, 1);
      tbl[19] = mkv(32'h66666666, 0, 2, 4'h7, 3, 1, 1);
      tbl[20] = mkv(32'h77777777, 0, 3, 4'h7, 3, 1, 1);
      tbl[21] = mkv(FTR,          0, 4, 4'h7, 3, 2, 1);
      // back-to-back packet with a repeated timestamp
      tbl[22] = mkv(HDR,          0, 1, 4'h7, 3, 2, 1);
      tbl[23] = mkv(32'h00000200, 0, 2, 4'h7, 3, 2, 1);
      tbl[24] = mkv(32'h00000000, 0, 2, 4'h7, 3, 2, 1);
      tbl[25] = mkv(32'h00000000, 0, 2, 4'h7, 3, 2, 1);
      tbl[26] = mkv(32'h00000000, 0, 3, 4'h7, 3, 2, 1);
      tbl[27] = mkv(FTR,          0, 4, 4'hF, 4, 3, 1);
      // TLAST word without tlast, then junk in the same hunt episode
      tbl[28] = mkv(TLW,          0, 0, 4'hF, 5, 3, 1);
      tbl[29] = mkv(32'h00000000, 0, 0, 4'hF, 5, 3, 1);
      // tlast on a timestamp word
      tbl[30] = mkv(HDR,          0, 1, 4'hF, 5, 3, 1);
      tbl[31] = mkv(32'h00000001, 1, 0, 4'hF, 6, 3, 1);

      // ---------------- reset state ----------------
      repeat (3) @(posedge master_clock);
      #1;
      check("rst.s_tready", {31'd0, s_tready}, 32'd0);
      check("rst.m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("rst.state",    {29'd0, state_dbg}, 32'd0);
      m_clear();
      check_stats("rst");
      @(negedge master_clock);
      resetn = 1'b1;
      @(posedge master_clock); #1;

      // ---------------- table ----------------
      for (int i = 0; i < 32; i++) begin
         send_word(tbl[i].d, tbl[i].l, 1'b0);
         check($sformatf("tbl%0d.state", i), {29'd0, state_dbg},    {29'd0, tbl[i].st});
         check($sformatf("tbl%0d.flags", i), {28'd0, err_flags},    {28'd0, tbl[i].fl});
         check($sformatf("tbl%0d.errc", i),  {16'd0, err_count},    {16'd0, tbl[i].ec});
         check($sformatf("tbl%0d.pkt", i),   {16'd0, packet_count}, {16'd0, tbl[i].pk});
         check($sformatf("tbl%0d.frm", i),   {16'd0, frame_count},  {16'd0, tbl[i].fr});
      end
      check("tbl.last",  last_timestamp,  32'h00000200);
      check("tbl.delta", timestamp_delta, 32'h00000000);
      drain();

      // ---------------- processed packet + frame ----------------
      do_clear("clear1");
      pkt(1'b0, 32'h00000100, 1'b0);
      frame_end();
      check_stats("proc");
      check("proc.last", last_timestamp, 32'h00000100);

      // ---------------- raw back-to-back ----------------
      do_clear("clear2");
      pkt(1'b1, 32'h00001000, 1'b0);
      pkt(1'b1, 32'h00001400, 1'b0);
      frame_end();
      check_stats("raw");
      check("raw.delta", timestamp_delta, 32'h00000400);
      check("raw.errc",  {16'd0, err_count}, 32'd0);

      // ---------------- timestamp wrap ----------------
      do_clear("clear3");
      pkt(1'b0, 32'hFFFFFF00, 1'b0);
      pkt(1'b0, 32'h00000100, 1'b0);
      frame_end();
      check_stats("wrap");
      check("wrap.delta", timestamp_delta, 32'h00000200);
      check("wrap.no_ts", {31'd0, err_flags[3]}, 32'd0);

      // ---------------- repeated timestamp ----------------
      do_clear("clear4");
      pkt(1'b0, 32'h00000300, 1'b0);
      pkt(1'b0, 32'h00000300, 1'b0);
      frame_end();
      check_stats("rep");
      check("rep.ts_flag", {31'd0, err_flags[3]}, 32'd1);

      // ---------------- junk before header ----------------
      do_clear("clear5");
      junk(5);
      pkt(1'b0, 32'h00000040, 1'b0);
      check_stats("junk");
      check("junk.errc", {16'd0, err_count}, 32'd1);

      // ---------------- bad footer then recovery ----------------
      do_clear("clear6");
      pkt(1'b0, 32'h00000050, 1'b1);
      pkt(1'b0, 32'h00000060, 1'b0);
      frame_end();
      check_stats("badftr");
      check("badftr.flag1", {31'd0, err_flags[1]}, 32'd1);

      // ---------------- clear coinciding with a good footer ----------------
      do_clear("clear7");
      send_word(HDR, 1'b0, 1'b0);
      send_word(32'h00000077, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_word($urandom, 1'b0, 1'b0);
      send_word(FTR, 1'b0, 1'b0, 1'b1);
      m_clear();
      check("clrwin.pkt", {16'd0, packet_count}, 32'd0);
      check("clrwin.state", {29'd0, state_dbg}, 32'd4);
      frame_end();
      check_stats("clrwin");

      // ---------------- reset mid-packet ----------------
      drain();
      ready_pct = 0;
      send_word(HDR, 1'b0, 1'b0);
      send_word(32'h00000099, 1'b0, 1'b0);
      resetn = 1'b0;
      #1;
      check("midrst.s_tready", {31'd0, s_tready}, 32'd0);
      check("midrst.m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("midrst.state",    {29'd0, state_dbg}, 32'd0);
      exp_q.delete();
      m_clear();
      check_stats("midrst");
      ready_pct = 100;
      repeat (2) @(posedge master_clock);
      @(negedge master_clock);
      resetn = 1'b1;
      @(posedge master_clock); #1;
      pkt(1'b0, 32'h00000500, 1'b0);
      frame_end();
      check_stats("postrst");
      drain();

      // ---------------- randomized frames under backpressure ----------------
      do_clear("clear8");
      ready_pct = 30;
      gap_pct   = 20;
      for (int it = 0; it < 30; it++) begin
         bit          mode;
         bit          bad;
         logic [31:0] ts;
         if ($urandom_range(0, 99) < 15) junk($urandom_range(1, 4));
         mode = ($urandom_range(0, 99) < 10);
         bad  = ($urandom_range(0, 99) < 15);
         ts   = (e_have && $urandom_range(0, 99) < 20) ? e_last : $urandom;
         pkt(mode, ts, bad);
         if (!bad && $urandom_range(0, 99) < 40) frame_end();
      end
      gap_pct = 0;
      check_stats("rand");
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
